// File: rtl/i2c_config_sequencer.sv
// Walks a {slave, sub, data} register table through an external I2C transfer controller,
// with power-up delay, per-entry NACK retry and failure reporting.
module i2c_config_sequencer #(
    parameter int unsigned CLK_FREQ       = 50000000,
    parameter int unsigned I2C_FREQ       = 20000,
    parameter int unsigned POWERUP_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned GAP_TICKS      = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [7:0]  iLUT_SIZE,
    output logic [7:0]  oLUT_INDEX,
    input  logic [23:0] iLUT_DATA,
    output logic        oI2C_CLK,
    output logic        oI2C_EN,
    output logic [23:0] oI2C_DATA,
    output logic        oGO,
    output logic        oWR,
    input  logic        iEND,
    input  logic        iACK,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERROR,
    output logic [7:0]  oFAIL_INDEX
);

    localparam int unsigned DIV      = CLK_FREQ / I2C_FREQ;
    localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DivLast = DW'(DIV - 1);
    localparam logic [DW-1:0] ClkLo   = DW'(DIV / 4);
    localparam logic [DW-1:0] ClkHi   = DW'((3 * DIV) / 4);
    localparam logic [31:0] PwrLast  = (POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0;
    localparam logic [31:0] GapTicks = GAP_TICKS;
    localparam logic [7:0]  MaxRetry = 8'(MAX_RETRY);

    generate
        if ((DIV < 4) || ((DIV % 4) != 0)) begin : g_cfg_err
            $error("i2c_config_sequencer: CLK_FREQ/I2C_FREQ must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        StPwrup, StLoad, StXfer, StGap, StCheck, StDone, StErr
    } state_t;

    state_t        r_state, w_state_next;
    logic [DW-1:0] r_div, w_div_next;
    logic          r_en, r_clk;
    logic [31:0]   r_pwr_cnt, w_pwr_cnt_next;
    logic [31:0]   r_gap_cnt, w_gap_cnt_next;
    logic [7:0]    r_index, w_index_next;
    logic [7:0]    r_retry, w_retry_next;
    logic [7:0]    r_size, w_size_next;
    logic [7:0]    r_fail_index, w_fail_index_next;
    logic [23:0]   r_data, w_data_next;
    logic          r_go, w_go_next;
    logic          r_ack, w_ack_next;
    logic [8:0]    w_index_inc;

    // EN/CLK are registered from the next count so they line up with r_div and are 0 in reset.
    assign w_div_next  = (r_div == DivLast) ? '0 : r_div + 1'b1;
    assign w_index_inc = {1'b0, r_index} + 9'd1;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_div        <= '0;
            r_en         <= 1'b0;
            r_clk        <= 1'b0;
            r_state      <= StPwrup;
            r_pwr_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_index      <= '0;
            r_retry      <= '0;
            r_size       <= '0;
            r_fail_index <= '0;
            r_data       <= '0;
            r_go         <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            r_div        <= w_div_next;
            r_en         <= (w_div_next == '0);
            r_clk        <= (w_div_next >= ClkLo) && (w_div_next < ClkHi);
            r_state      <= w_state_next;
            r_pwr_cnt    <= w_pwr_cnt_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_index      <= w_index_next;
            r_retry      <= w_retry_next;
            r_size       <= w_size_next;
            r_fail_index <= w_fail_index_next;
            r_data       <= w_data_next;
            r_go         <= w_go_next;
            r_ack        <= w_ack_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pwr_cnt_next    = r_pwr_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_index_next      = r_index;
        w_retry_next      = r_retry;
        w_size_next       = r_size;
        w_fail_index_next = r_fail_index;
        w_data_next       = r_data;
        w_go_next         = r_go;
        w_ack_next        = r_ack;
        unique case (r_state)
            StPwrup: begin
                if (r_pwr_cnt >= PwrLast) begin
                    w_size_next  = iLUT_SIZE;
                    w_index_next = '0;
                    w_retry_next = '0;
                    w_state_next = (iLUT_SIZE == 8'd0) ? StDone : StLoad;
                end else begin
                    w_pwr_cnt_next = r_pwr_cnt + 32'd1;
                end
            end
            StLoad: begin
                if (r_en) begin
                    w_data_next  = iLUT_DATA;
                    w_go_next    = 1'b1;
                    w_state_next = StXfer;
                end
            end
            StXfer: begin
                if (r_en && iEND) begin
                    w_ack_next     = iACK;
                    w_go_next      = 1'b0;
                    w_gap_cnt_next = '0;
                    w_state_next   = StGap;
                end
            end
            StGap: begin
                // Holding GO low lets the controller clear its step counter and END.
                if (r_gap_cnt >= GapTicks) begin
                    w_state_next = StCheck;
                end else if (r_en) begin
                    w_gap_cnt_next = r_gap_cnt + 32'd1;
                end
            end
            StCheck: begin
                if (!r_ack) begin
                    if (w_index_inc < {1'b0, r_size}) begin
                        w_index_next = w_index_inc[7:0];
                        w_retry_next = '0;
                        w_state_next = StLoad;
                    end else begin
                        w_state_next = StDone;
                    end
                end else if (r_retry < MaxRetry) begin
                    w_retry_next = r_retry + 8'd1;
                    w_state_next = StLoad;
                end else begin
                    w_fail_index_next = r_index;
                    w_state_next      = StErr;
                end
            end
            StDone, StErr: begin
                if (iSTART) begin
                    w_size_next       = iLUT_SIZE;
                    w_index_next      = '0;
                    w_retry_next      = '0;
                    w_fail_index_next = '0;
                    w_state_next      = (iLUT_SIZE == 8'd0) ? StDone : StLoad;
                end
            end
            default: w_state_next = StPwrup;
        endcase
    end

    assign oLUT_INDEX  = r_index;
    assign oI2C_CLK    = r_clk;
    assign oI2C_EN     = r_en;
    assign oI2C_DATA   = r_data;
    assign oGO         = r_go;
    assign oWR         = 1'b1;
    assign oBUSY       = (r_state != StDone) && (r_state != StErr);
    assign oDONE       = (r_state == StDone);
    assign oERROR      = (r_state == StErr);
    assign oFAIL_INDEX = r_fail_index;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Table-driven bench for i2c_config_sequencer with a small ack/NACK controller model.
module tb_i2c_config_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic [7:0]  iLUT_SIZE = 8'd3;
    logic [23:0] iLUT_DATA;
    logic        iEND = 1'b0;
    logic        iACK = 1'b0;
    logic [7:0]  oLUT_INDEX;
    logic        oI2C_CLK, oI2C_EN, oGO, oWR, oBUSY, oDONE, oERROR;
    logic [23:0] oI2C_DATA;
    logic [7:0]  oFAIL_INDEX;

    i2c_config_sequencer #(
        .CLK_FREQ      (160000),
        .I2C_FREQ      (20000),
        .POWERUP_CYCLES(20),
        .MAX_RETRY     (2),
        .GAP_TICKS     (2)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSTART     (iSTART),
        .iLUT_SIZE  (iLUT_SIZE),
        .oLUT_INDEX (oLUT_INDEX),
        .iLUT_DATA  (iLUT_DATA),
        .oI2C_CLK   (oI2C_CLK),
        .oI2C_EN    (oI2C_EN),
        .oI2C_DATA  (oI2C_DATA),
        .oGO        (oGO),
        .oWR        (oWR),
        .iEND       (iEND),
        .iACK       (iACK),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE),
        .oERROR     (oERROR),
        .oFAIL_INDEX(oFAIL_INDEX)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [23:0] lut_word(input logic [7:0] i);
        return {8'h42, i, i ^ 8'hA5};
    endfunction

    assign iLUT_DATA = lut_word(oLUT_INDEX);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Controller model: END after 3 ticks of GO, NACK while the entry still has NACKs queued.
    int          nack_left [256];
    logic [23:0] got_data[$];
    int          unstable = 0;
    logic        prev_go = 1'b0;
    logic        cur_nack = 1'b0;
    logic [23:0] cur_data = '0;
    int          ctl_ticks = 0;

    always @(negedge iCLK) begin
        if (oGO && !prev_go) begin
            got_data.push_back(oI2C_DATA);
            cur_data  = oI2C_DATA;
            ctl_ticks = 0;
            cur_nack  = (nack_left[oLUT_INDEX] != 0);
            if (cur_nack && nack_left[oLUT_INDEX] != 255)
                nack_left[oLUT_INDEX] = nack_left[oLUT_INDEX] - 1;
        end
        if (oGO && oI2C_DATA !== cur_data) unstable++;
        if (oGO) begin
            if (oI2C_EN) begin
                ctl_ticks++;
                if (ctl_ticks >= 3) begin
                    iEND = 1'b1;
                    iACK = cur_nack;
                end
            end
        end else begin
            iEND = 1'b0;
            iACK = 1'b0;
        end
        prev_go = oGO;
    end

    task automatic do_reset(input logic [7:0] size);
        @(negedge iCLK);
        iRST      = 1'b1;
        iSTART    = 1'b0;
        iLUT_SIZE = size;
        for (int i = 0; i < 256; i++) nack_left[i] = 0;
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic wait_end(input int bound, output int cyc);
        cyc = 0;
        while (!(oDONE || oERROR) && cyc < bound) begin
            @(negedge iCLK);
            cyc++;
        end
    endtask

    task automatic wait_go(input int bound, output int cyc);
        cyc = 0;
        while (!oGO && cyc < bound) begin
            @(negedge iCLK);
            cyc++;
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  size;
        logic [7:0]  nack_idx;
        int          nack_times;
        bit          start_in_xfer;
        bit          exp_done;
        bit          exp_err;
        logic [7:0]  exp_fail;
        int          exp_txns;
        logic [7:0]  exp_last;
        logic [39:0] exp_seq;   // first up to five issued indices, byte k at [8k+:8]
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    initial begin
        int          cyc;
        int          base;
        int          u0;
        int          n;
        logic [39:0] seq;
        logic [7:0]  idx;

        vecs[0] = '{"normal",     8'd3,   8'd0, 0,   1'b0, 1'b1, 1'b0, 8'd0, 3,   8'd2,
                    40'h00_00_02_01_00};
        vecs[1] = '{"retry",      8'd2,   8'd1, 2,   1'b0, 1'b1, 1'b0, 8'd0, 4,   8'd1,
                    40'h00_01_01_01_00};
        vecs[2] = '{"fail",       8'd3,   8'd2, 255, 1'b0, 1'b0, 1'b1, 8'd2, 5,   8'd2,
                    40'h02_02_02_01_00};
        vecs[3] = '{"single",     8'd1,   8'd0, 0,   1'b0, 1'b1, 1'b0, 8'd0, 1,   8'd0,
                    40'h00_00_00_00_00};
        vecs[4] = '{"start_xfer", 8'd3,   8'd0, 0,   1'b1, 1'b1, 1'b0, 8'd0, 3,   8'd2,
                    40'h00_00_02_01_00};
        vecs[5] = '{"size255",    8'd255, 8'd0, 0,   1'b0, 1'b1, 1'b0, 8'd0, 255, 8'd254,
                    40'h04_03_02_01_00};

        // Reset values
        for (int i = 0; i < 256; i++) nack_left[i] = 0;
        repeat (3) @(negedge iCLK);
        check("rst_go", oGO, 0);
        check("rst_en", oI2C_EN, 0);
        check("rst_clk", oI2C_CLK, 0);
        check("rst_data", oI2C_DATA, 0);
        check("rst_index", oLUT_INDEX, 0);
        check("rst_busy", oBUSY, 1);
        check("rst_done", oDONE, 0);
        check("rst_error", oERROR, 0);
        check("rst_fail_index", oFAIL_INDEX, 0);
        check("wr_const", oWR, 1);

        // Divider: EN every 8 cycles, CLK high on counts 2..5
        iRST = 1'b0;
        cyc = 0;
        while (!oI2C_EN && cyc < 16) begin
            @(negedge iCLK);
            cyc++;
        end
        check("div_first_en_cycle", cyc, 8);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("div_en_%0d", k), oI2C_EN, ((k % 8) == 0) ? 1 : 0);
            check($sformatf("div_clk_%0d", k), oI2C_CLK,
                  (((k % 8) >= 2) && ((k % 8) <= 5)) ? 1 : 0);
            @(negedge iCLK);
        end

        // Table of full-run scenarios
        for (int v = 0; v < NVEC; v++) begin
            do_reset(vecs[v].size);
            if (vecs[v].nack_times != 0) nack_left[vecs[v].nack_idx] = vecs[v].nack_times;
            base = got_data.size();
            u0   = unstable;
            if (vecs[v].start_in_xfer) begin
                wait_go(100, cyc);
                check({vecs[v].name, "_go_seen"}, oGO, 1);
                iSTART    = 1'b1;
                iLUT_SIZE = 8'd1;
                @(negedge iCLK);
                iSTART = 1'b0;
            end
            wait_end(20000, cyc);
            check({vecs[v].name, "_finished"}, oDONE | oERROR, 1);
            check({vecs[v].name, "_done"}, oDONE, vecs[v].exp_done);
            check({vecs[v].name, "_error"}, oERROR, vecs[v].exp_err);
            check({vecs[v].name, "_busy"}, oBUSY, 0);
            check({vecs[v].name, "_fail_index"}, oFAIL_INDEX, vecs[v].exp_fail);
            check({vecs[v].name, "_txns"}, got_data.size() - base, vecs[v].exp_txns);
            check({vecs[v].name, "_last_index"}, oLUT_INDEX, vecs[v].exp_last);
            check({vecs[v].name, "_data_stable"}, unstable - u0, 0);
            n   = (vecs[v].exp_txns < 5) ? vecs[v].exp_txns : 5;
            seq = vecs[v].exp_seq;
            for (int k = 0; k < n; k++) begin
                idx = seq[8*k +: 8];
                if (base + k < got_data.size())
                    check($sformatf("%s_data_%0d", vecs[v].name, k), got_data[base + k],
                          lut_word(idx));
                else
                    check($sformatf("%s_data_%0d_missing", vecs[v].name, k), 0, 1);
            end
        end

        // Empty table: DONE exactly 20 cycles after release, no GO
        do_reset(8'd0);
        base = got_data.size();
        wait_end(100, cyc);
        check("size0_done", oDONE, 1);
        check("size0_cycles", cyc, 20);
        check("size0_no_go", got_data.size() - base, 0);

        // Restart from ERR skips the power-up wait and clears status
        do_reset(8'd3);
        nack_left[2] = 255;
        wait_end(2000, cyc);
        check("err_state", oERROR, 1);
        check("err_fail_index", oFAIL_INDEX, 2);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        check("restart_error_clr", oERROR, 0);
        check("restart_fail_clr", oFAIL_INDEX, 0);
        check("restart_busy", oBUSY, 1);
        wait_go(12, cyc);
        check("restart_go_fast", oGO, 1);
        check("restart_index", oLUT_INDEX, 0);
        check("restart_data", oI2C_DATA, lut_word(8'd0));

        // Reset during entry 1: GO drops at once, rerun from entry 0 after full power-up
        do_reset(8'd3);
        cyc = 0;
        while (!(oGO && oLUT_INDEX == 8'd1) && cyc < 500) begin
            @(negedge iCLK);
            cyc++;
        end
        check("midrst_entry1_seen", oGO && (oLUT_INDEX == 8'd1), 1);
        iRST = 1'b1;
        #1;
        check("midrst_go_async", oGO, 0);
        check("midrst_index", oLUT_INDEX, 0);
        @(negedge iCLK);
        iRST = 1'b0;
        wait_go(40, cyc);
        check("midrst_rerun_go", oGO, 1);
        checks++;
        if (cyc < 21 || cyc > 29) begin
            errors++;
            $display("FAIL midrst_rerun_wait: got %0d cycles expected 21..29", cyc);
        end
        check("midrst_rerun_index", oLUT_INDEX, 0);
        check("midrst_rerun_data", oI2C_DATA, lut_word(8'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
